// File: rtl/rename_pkg.sv
// Shared types for the rename stage: register/checkpoint ids, map snapshot
// and checkpoint entry layout, plus the identity map loaded at reset.
package rename_pkg;
    localparam int NUM_VREG = 16;
    localparam int NUM_PREG = 48;
    localparam int RENAME_W = 2;
    localparam int NUM_CKPT = 4;

    localparam int VW  = $clog2(NUM_VREG);
    localparam int PW  = $clog2(NUM_PREG);
    localparam int CW  = $clog2(NUM_CKPT);
    localparam int FCW = $clog2(NUM_PREG) + 1;

    typedef logic [VW-1:0]  vreg_t;
    typedef logic [PW-1:0]  preg_t;
    typedef logic [CW-1:0]  ckpt_id_t;
    typedef logic [FCW-1:0] count_t;
    typedef preg_t [NUM_VREG-1:0] map_t;

    typedef struct packed {
        logic                valid;
        map_t                map;
        logic [NUM_PREG-1:0] alloc;
    } checkpoint_t;

    function automatic map_t reset_map();
        map_t m;
        for (int unsigned v = 0; v < NUM_VREG; v++) begin
            m[v] = preg_t'(v);
        end
        return m;
    endfunction
endpackage

// File: rtl/free_alloc.sv
// Free physical-register bit vector with population count and a picker
// that offers the RENAME_W lowest-index free registers each cycle.
module free_alloc
    import rename_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PREG-1:0]                clr_mask,
    input  logic [NUM_PREG-1:0]                commit_mask,
    input  logic [NUM_PREG-1:0]                restore_mask,
    output logic [FCW-1:0]                     free_count,
    output logic [RENAME_W-1:0][PW-1:0]        pick_idx,
    output logic [RENAME_W-1:0][NUM_PREG-1:0]  pick_oh
);
    localparam logic [NUM_PREG-1:0] RESET_FREE =
        {{(NUM_PREG-NUM_VREG){1'b1}}, {NUM_VREG{1'b0}}};

    logic [NUM_PREG-1:0] free_vec;
    logic [NUM_PREG-1:0] avail;

    always_ff @(posedge clk) begin
        if (rst) begin
            free_vec <= RESET_FREE;
        end else begin
            free_vec <= (free_vec & ~clr_mask) | commit_mask | restore_mask;
        end
    end

    // Commit must never return a register that is already free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((free_vec & commit_mask) == '0);
        end
    end

    always_comb begin
        free_count = '0;
        for (int unsigned i = 0; i < NUM_PREG; i++) begin
            free_count = free_count + count_t'(free_vec[i]);
        end
    end

    // Descending scan so the last hit, i.e. the lowest free index, wins.
    always_comb begin
        avail    = free_vec;
        pick_idx = '0;
        pick_oh  = '0;
        for (int unsigned k = 0; k < RENAME_W; k++) begin
            for (int unsigned i = NUM_PREG; i > 0; i--) begin
                if (avail[i-1]) begin
                    pick_idx[k] = preg_t'(i-1);
                    pick_oh[k]  = {{(NUM_PREG-1){1'b0}}, 1'b1} << (i-1);
                end
            end
            avail = avail & ~pick_oh[k];
        end
    end
endmodule

// File: rtl/rename_unit.sv
// Superscalar rename stage: map table with intra-group bypass, free-list
// allocation/commit frees, and a circular buffer of branch checkpoints.
module rename_unit
    import rename_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RENAME_W-1:0]    ren_valid,
    input  logic [RENAME_W-1:0]    ren_wr,
    input  logic [RENAME_W*VW-1:0] ren_dst,
    input  logic [RENAME_W*VW-1:0] ren_src_a,
    input  logic [RENAME_W*VW-1:0] ren_src_b,
    input  logic                   ren_ckpt,
    output logic                   ren_ready,
    output logic [RENAME_W*PW-1:0] ren_psrc_a,
    output logic [RENAME_W*PW-1:0] ren_psrc_b,
    output logic [RENAME_W*PW-1:0] ren_pdst,
    output logic [RENAME_W*PW-1:0] ren_pold,
    output logic [CW-1:0]          ren_ckpt_id,
    input  logic [RENAME_W-1:0]    free_valid,
    input  logic [RENAME_W*PW-1:0] free_preg,
    input  logic                   ckpt_release,
    input  logic                   ckpt_restore,
    input  logic [CW-1:0]          ckpt_restore_id,
    output logic [FCW-1:0]         free_count
);
    map_t        map_q;
    map_t        map_grp;
    checkpoint_t ckpt_q [NUM_CKPT];
    ckpt_id_t    head_q;
    ckpt_id_t    tail_q;

    logic [RENAME_W-1:0]               wr;
    vreg_t                             dst [RENAME_W];
    vreg_t                             sa  [RENAME_W];
    vreg_t                             sb  [RENAME_W];
    preg_t                             pdst [RENAME_W];
    count_t                            need;
    logic                              ckpt_full;
    logic [NUM_PREG-1:0]               alloc_vec;
    logic [NUM_PREG-1:0]               commit_mask;
    logic [NUM_PREG-1:0]               restore_mask;
    logic [RENAME_W-1:0][PW-1:0]       pick_idx;
    logic [RENAME_W-1:0][NUM_PREG-1:0] pick_oh;

    free_alloc u_free_alloc (
        .clk          (clk),
        .rst          (rst),
        .clr_mask     (ren_ready ? alloc_vec : '0),
        .commit_mask  (commit_mask),
        .restore_mask (restore_mask),
        .free_count   (free_count),
        .pick_idx     (pick_idx),
        .pick_oh      (pick_oh)
    );

    assign wr          = ren_valid & ren_wr;
    assign ren_ckpt_id = tail_q;

    always_comb begin
        need        = '0;
        ckpt_full   = 1'b1;
        commit_mask = '0;
        for (int unsigned k = 0; k < RENAME_W; k++) begin
            dst[k] = ren_dst[k*VW +: VW];
            sa[k]  = ren_src_a[k*VW +: VW];
            sb[k]  = ren_src_b[k*VW +: VW];
            need   = need + count_t'(wr[k]);
            if (free_valid[k]) begin
                commit_mask[free_preg[k*PW +: PW]] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            ckpt_full = ckpt_full & ckpt_q[i].valid;
        end
        restore_mask = ckpt_restore ? ckpt_q[ckpt_restore_id].alloc : '0;
    end

    // A release in the same cycle frees the head slot the take will reuse.
    assign ren_ready = !rst && !ckpt_restore && (free_count >= need) &&
                       (!ren_ckpt || !ckpt_full || ckpt_release);

    // Writing slot k takes pick number = count of writing slots below k.
    always_comb begin
        int unsigned rank;
        rank      = 0;
        alloc_vec = '0;
        for (int unsigned k = 0; k < RENAME_W; k++) begin
            pdst[k] = '0;
            for (int unsigned j = 0; j < RENAME_W; j++) begin
                if (j == rank) begin
                    pdst[k] = pick_idx[j];
                    if (wr[k]) alloc_vec = alloc_vec | pick_oh[j];
                end
            end
            if (wr[k]) rank++;
        end
    end

    always_comb begin
        preg_t pa, pb, po;
        map_grp    = map_q;
        ren_psrc_a = '0;
        ren_psrc_b = '0;
        ren_pold   = '0;
        ren_pdst   = '0;
        for (int unsigned k = 0; k < RENAME_W; k++) begin
            pa = map_q[sa[k]];
            pb = map_q[sb[k]];
            po = map_q[dst[k]];
            for (int unsigned j = 0; j < k; j++) begin
                if (wr[j] && dst[j] == sa[k])  pa = pdst[j];
                if (wr[j] && dst[j] == sb[k])  pb = pdst[j];
                if (wr[j] && dst[j] == dst[k]) po = pdst[j];
            end
            ren_psrc_a[k*PW +: PW] = pa;
            ren_psrc_b[k*PW +: PW] = pb;
            ren_pold[k*PW +: PW]   = po;
            ren_pdst[k*PW +: PW]   = pdst[k];
            if (wr[k]) map_grp[dst[k]] = pdst[k];
        end
    end

    // Restore drops entries younger than r, measured as distance from head.
    always_ff @(posedge clk) begin
        if (rst) begin
            map_q  <= reset_map();
            head_q <= '0;
            tail_q <= '0;
            for (int unsigned i = 0; i < NUM_CKPT; i++) begin
                ckpt_q[i] <= '0;
            end
        end else begin
            if (ckpt_restore) begin
                map_q  <= ckpt_q[ckpt_restore_id].map;
                tail_q <= ckpt_restore_id + 1'b1;
                for (int unsigned i = 0; i < NUM_CKPT; i++) begin
                    if (ckpt_id_t'(ckpt_id_t'(i) - head_q) >
                        ckpt_id_t'(ckpt_restore_id - head_q)) begin
                        ckpt_q[i].valid <= 1'b0;
                    end
                end
            end else if (ren_ready) begin
                map_q <= map_grp;
                for (int unsigned i = 0; i < NUM_CKPT; i++) begin
                    if (ckpt_q[i].valid) begin
                        ckpt_q[i].alloc <= ckpt_q[i].alloc | alloc_vec;
                    end
                end
            end
            if (ckpt_release && ckpt_q[head_q].valid) begin
                ckpt_q[head_q].valid <= 1'b0;
                head_q <= head_q + 1'b1;
            end
            if (!ckpt_restore && ren_ready && ren_ckpt) begin
                ckpt_q[tail_q] <= '{valid: 1'b1, map: map_grp, alloc: '0};
                tail_q <= tail_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit: allocation, bypass, back-pressure,
// checkpoint take/release/restore, and reset behaviour.
module tb_rename_unit;
    import rename_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [RENAME_W-1:0]    ren_valid, ren_wr;
    logic [RENAME_W*VW-1:0] ren_dst, ren_src_a, ren_src_b;
    logic                   ren_ckpt, ren_ready;
    logic [RENAME_W*PW-1:0] ren_psrc_a, ren_psrc_b, ren_pdst, ren_pold;
    logic [CW-1:0]          ren_ckpt_id;
    logic [RENAME_W-1:0]    free_valid;
    logic [RENAME_W*PW-1:0] free_preg;
    logic                   ckpt_release, ckpt_restore;
    logic [CW-1:0]          ckpt_restore_id;
    logic [FCW-1:0]         free_count;

    int checks = 0;
    int errors = 0;

    rename_unit dut (
        .clk             (clk),
        .rst             (rst),
        .ren_valid       (ren_valid),
        .ren_wr          (ren_wr),
        .ren_dst         (ren_dst),
        .ren_src_a       (ren_src_a),
        .ren_src_b       (ren_src_b),
        .ren_ckpt        (ren_ckpt),
        .ren_ready       (ren_ready),
        .ren_psrc_a      (ren_psrc_a),
        .ren_psrc_b      (ren_psrc_b),
        .ren_pdst        (ren_pdst),
        .ren_pold        (ren_pold),
        .ren_ckpt_id     (ren_ckpt_id),
        .free_valid      (free_valid),
        .free_preg       (free_preg),
        .ckpt_release    (ckpt_release),
        .ckpt_restore    (ckpt_restore),
        .ckpt_restore_id (ckpt_restore_id),
        .free_count      (free_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pdst_of(input int k);
        return 32'(ren_pdst[k*PW +: PW]);
    endfunction
    function automatic logic [31:0] pold_of(input int k);
        return 32'(ren_pold[k*PW +: PW]);
    endfunction
    function automatic logic [31:0] psa_of(input int k);
        return 32'(ren_psrc_a[k*PW +: PW]);
    endfunction
    function automatic logic [31:0] psb_of(input int k);
        return 32'(ren_psrc_b[k*PW +: PW]);
    endfunction

    task automatic clear_inputs();
        ren_valid = '0; ren_wr = '0; ren_dst = '0; ren_src_a = '0; ren_src_b = '0;
        ren_ckpt = 1'b0; free_valid = '0; free_preg = '0;
        ckpt_release = 1'b0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
    endtask

    task automatic slot(input int k, input int w, input int d, input int a, input int b);
        ren_valid[k] = 1'b1;
        ren_wr[k]    = (w != 0);
        ren_dst[k*VW +: VW]   = vreg_t'(d);
        ren_src_a[k*VW +: VW] = vreg_t'(a);
        ren_src_b[k*VW +: VW] = vreg_t'(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_map(input string tag, input int v, input int exp);
        slot(0, 0, 0, v, v);
        #1;
        check(tag, psa_of(0), exp);
        step();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        slot(0, 1, 3, 0, 0);
        @(posedge clk);
        #1;
        check("rst_ready", ren_ready, 0);
        step();
        rst = 1'b0;
        check("rst_free_count", free_count, 32);
        check("rst_ckpt_id", ren_ckpt_id, 0);

        // two writes v3, v5; slot 1 reads v3 through the bypass
        slot(0, 1, 3, 3, 5);
        slot(1, 1, 5, 3, 5);
        #1;
        check("g1_ready", ren_ready, 1);
        check("g1_pdst0", pdst_of(0), 16);
        check("g1_pdst1", pdst_of(1), 17);
        check("g1_pold0", pold_of(0), 3);
        check("g1_pold1", pold_of(1), 5);
        check("g1_psa0", psa_of(0), 3);
        check("g1_psa1_bypass", psa_of(1), 16);
        check("g1_psb1", psb_of(1), 5);
        step();
        check("g1_free_count", free_count, 30);
        check_map("g1_map_v3", 3, 16);
        check_map("g1_map_v5", 5, 17);

        // same-dst chain within one group
        do_reset();
        slot(0, 1, 2, 0, 0);
        slot(1, 1, 2, 2, 2);
        #1;
        check("g2_pdst0", pdst_of(0), 16);
        check("g2_pold0", pold_of(0), 2);
        check("g2_psa1", psa_of(1), 16);
        check("g2_psb1", psb_of(1), 16);
        check("g2_pold1", pold_of(1), 16);
        check("g2_pdst1", pdst_of(1), 17);
        step();
        check("g2_free_count", free_count, 30);
        check_map("g2_map_v2", 2, 17);

        // drain to one free register, then back-pressure
        do_reset();
        for (int i = 0; i < 15; i++) begin
            slot(0, 1, 0, 0, 0);
            slot(1, 1, 0, 0, 0);
            #1;
            step();
        end
        slot(0, 1, 0, 0, 0);
        slot(1, 0, 0, 0, 0);
        #1;
        step();
        check("dr_free_count1", free_count, 1);
        slot(0, 1, 7, 0, 0);
        slot(1, 1, 8, 0, 0);
        #1;
        check("dr_ready_low", ren_ready, 0);
        step();
        check("dr_no_change_count", free_count, 1);
        check_map("dr_map_v7", 7, 7);
        check_map("dr_map_v0", 0, 46);
        slot(0, 1, 7, 0, 0);
        slot(1, 1, 8, 0, 0);
        free_valid[0] = 1'b1;
        free_preg[0 +: PW] = preg_t'(20);
        #1;
        check("dr_free_not_same_cycle", ren_ready, 0);
        step();
        check("dr_free_count2", free_count, 2);
        slot(0, 1, 7, 0, 0);
        slot(1, 1, 8, 0, 0);
        #1;
        check("dr_ready_after_free", ren_ready, 1);
        check("dr_pdst0", pdst_of(0), 20);
        check("dr_pdst1", pdst_of(1), 47);
        step();
        check("dr_free_count0", free_count, 0);
        slot(0, 0, 0, 8, 8);
        #1;
        check("dr_readonly_ready", ren_ready, 1);
        check("dr_map_v8", psa_of(0), 47);
        step();

        // checkpoint then restore, with a rename group presented alongside
        do_reset();
        slot(0, 1, 1, 0, 0);
        ren_ckpt = 1'b1;
        #1;
        check("ck_ready", ren_ready, 1);
        check("ck_pdst0", pdst_of(0), 16);
        check("ck_id0", ren_ckpt_id, 0);
        step();
        slot(0, 1, 1, 1, 0);
        slot(1, 1, 4, 1, 0);
        free_valid[0] = 1'b1;
        free_preg[0 +: PW] = preg_t'(5);
        #1;
        check("ck_pdst_a", pdst_of(0), 17);
        check("ck_pdst_b", pdst_of(1), 18);
        check("ck_pold_a", pold_of(0), 16);
        check("ck_pold_b", pold_of(1), 4);
        check("ck_psa_a", psa_of(0), 16);
        check("ck_psa_b", psa_of(1), 17);
        step();
        check("ck_free_count_pre", free_count, 30);
        ckpt_restore = 1'b1;
        ckpt_restore_id = '0;
        slot(0, 1, 9, 0, 0);
        #1;
        check("rs_ready_low", ren_ready, 0);
        step();
        check("rs_free_count", free_count, 32);
        check_map("rs_map_v1", 1, 16);
        check_map("rs_map_v4", 4, 4);
        check_map("rs_map_v9", 9, 9);
        slot(0, 1, 6, 0, 0);
        slot(1, 1, 7, 0, 0);
        ren_ckpt = 1'b1;
        #1;
        check("rs_pdst0", pdst_of(0), 5);
        check("rs_pdst1", pdst_of(1), 17);
        check("rs_tail1", ren_ckpt_id, 1);
        step();
        check("rs_free_count_post", free_count, 30);

        // fill the checkpoint buffer, release+take, partial restore
        do_reset();
        for (int i = 0; i < NUM_CKPT; i++) begin
            slot(0, 0, 0, 0, 0);
            ren_ckpt = 1'b1;
            #1;
            check("cf_take_ready", ren_ready, 1);
            check("cf_take_id", ren_ckpt_id, i);
            step();
        end
        slot(0, 0, 0, 0, 0);
        ren_ckpt = 1'b1;
        #1;
        check("cf_full", ren_ready, 0);
        step();
        ren_ckpt = 1'b1;
        ckpt_release = 1'b1;
        #1;
        check("cf_rel_take_ready", ren_ready, 1);
        check("cf_rel_take_id", ren_ckpt_id, 0);
        step();
        ren_ckpt = 1'b1;
        #1;
        check("cf_full_again", ren_ready, 0);
        step();
        ckpt_restore = 1'b1;
        ckpt_restore_id = 2'd2;
        step();
        ren_ckpt = 1'b1;
        #1;
        check("cf_after_rs_ready", ren_ready, 1);
        check("cf_after_rs_id", ren_ckpt_id, 3);
        step();
        ren_ckpt = 1'b1;
        #1;
        check("cf_after_rs_id2", ren_ckpt_id, 0);
        step();
        ren_ckpt = 1'b1;
        #1;
        check("cf_full_third", ren_ready, 0);
        step();

        // reset with a restore pending discards the restore
        rst = 1'b1;
        ckpt_restore = 1'b1;
        ckpt_restore_id = 2'd2;
        #1;
        check("rr_ready", ren_ready, 0);
        step();
        rst = 1'b0;
        check("rr_free_count", free_count, 32);
        check("rr_ckpt_id", ren_ckpt_id, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Superscalar register-rename stage for the out-of-order core. It merges the free-register list and the translation table into one block.
- Renames up to RENAME_W instructions per cycle. Returns freed physical registers at commit.
- Holds NUM_CKPT branch checkpoints for single-cycle mispredict recovery.
- Sits between decode and dispatch. The commit unit drives its free port.

Parameters:
- NUM_VREG, 16, architectural (virtual) registers
- NUM_PREG, 48, physical registers; must be > NUM_VREG + RENAME_W
- RENAME_W, 2, rename slots per cycle; also commit-free slots per cycle
- NUM_CKPT, 4, checkpoint slots; power of two

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ren_valid  in  RENAME_W  slot k holds an instruction
- ren_wr  in  RENAME_W  slot k writes a destination
- ren_dst  in  RENAME_W*VW  destination vreg per slot (VW = clog2 NUM_VREG)
- ren_src_a, ren_src_b  in  RENAME_W*VW  source vregs per slot
- ren_ckpt  in  1  take a checkpoint after this group
- ren_ready  out  1  group accepted this cycle
- ren_psrc_a, ren_psrc_b  out  RENAME_W*PW  renamed sources (PW = clog2 NUM_PREG)
- ren_pdst  out  RENAME_W*PW  newly allocated preg per slot
- ren_pold  out  RENAME_W*PW  previous mapping of the dst; goes to the ROB for later freeing
- ren_ckpt_id  out  CW  id of the checkpoint taken (CW = clog2 NUM_CKPT)
- free_valid  in  RENAME_W  commit frees preg in slot k
- free_preg  in  RENAME_W*PW  pregs to free
- ckpt_release  in  1  oldest checkpoint resolved correctly
- ckpt_restore  in  1  mispredict recovery
- ckpt_restore_id  in  CW  checkpoint to restore
- free_count  out  clog2(NUM_PREG)+1  number of free pregs

Behaviour:

Reset (rst high at a clk edge):
- map[v] = v.
- free vector: bits NUM_VREG..NUM_PREG-1 set.
- All checkpoints invalid; head = tail = 0.
- Outputs: ren_ready = 0 during the reset cycle; free_count = NUM_PREG-NUM_VREG the cycle after.
- Reset mid-operation discards everything, including any pending restore.

Rename path (combinational; state updates at the clk edge):
- need = popcount(ren_valid & ren_wr).
- ren_ready = !rst && !ckpt_restore && free_count >= need && (!ren_ckpt || checkpoint not full).
- ren_valid with ren_ready low: nothing changes; decode holds the group. All-or-nothing, never partial.
- Allocation: take the lowest-index free pregs, assigned in ascending slot order. ren_pdst is don't-care for non-writing slots.
- Intra-group bypass: for slot k, a source or old-dst vreg written by an earlier slot j<k resolves to slot j's ren_pdst (the youngest such j). Otherwise it resolves to map[] as it stood at the start of the cycle.
- On acceptance, for each writing slot: map[dst] = pdst and the free bit for pdst is cleared. When two slots write the same dst, the higher slot wins.
- Freed pregs are not visible to the same-cycle allocation. They become allocatable the next cycle.

Free path:
- Each free_valid slot sets its free bit at the edge.
- Freeing an already-free preg is illegal; assert in simulation.

Checkpoints (circular buffer, head = oldest):
- Each entry holds: valid, map snapshot, alloc mask.
- Take: when ren_ckpt is accepted, entry[tail] gets map with this group applied and alloc = 0. ren_ckpt_id = tail; tail advances.
- Full: when all NUM_CKPT entries are valid, ren_ready = 0 for a group with ren_ckpt set.
- Tracking: every allocation ORs pdst bits into the alloc mask of every valid entry. This includes allocations in the group that takes a checkpoint, but only for entries that existed before that group.
- Release: invalidate entry[head] and advance head. Release with no valid entry is ignored.
- Restore id r:
  - map = entry[r].map.
  - free |= entry[r].alloc, also ORed with this cycle's commit frees.
  - Entries r+1..tail-1 are invalidated; tail = r+1 (entry r stays valid).
  - ren_ready = 0 that cycle; rename is ignored.
- Same cycle as release:
  - Restore and release together are applied as restore then release.
  - Release together with take is legal.
- Latency: rename results appear in the same cycle; map and free-list updates are visible the next cycle; restore completes in one cycle.

Decomposition:
- rename_pkg holds:
  - preg_t, vreg_t, ckpt_id_t typedefs
  - checkpoint_t struct: valid, map array, alloc mask
  - reset-map function
- One sub-module, free_alloc: free bit vector, popcount, lowest-RENAME_W priority picker with per-slot one-hot and index outputs.
- Map table, bypass and checkpoint buffer stay in rename_unit.

Test Plan:
- Reset, then one group with slots 0 and 1 writing v3 and v5 -> pdst 16 and 17; pold 3 and 5; free_count 32→30.
- Slot 0 writes v2 -> p16; slot 1 reads v2 and writes v2 -> psrc_a = 16, pold = 16, pdst = 17; next cycle map[v2] = 17.
- Drain to free_count = 1 and present a two-write group -> ren_ready = 0 and no state change. free_valid p20 -> the next cycle's group is accepted.
- ren_ckpt with v1→p16 gives id 0. Then rename v1→p17 and v4→p18 and free p5. Restore 0 -> map[v1] = 16, map[v4] = 4; p17, p18 and p5 free; tail = 1.
- Take 4 checkpoints; a 5th ckpt group -> ren_ready = 0. Release and take in the same cycle -> accepted, id 0 reused.
- Restore and a valid rename group in the same cycle -> rename ignored, ren_ready = 0, no allocation.
